program_sequencer: RTL and testbench

Program counter and control-flow stage that sits directly upstream of computational_unit. It generates the program-memory address each cycle, then advances sequentially or redirects on jump, conditional jump, subroutine call and return. Conditional jumps use the r_eq_0 flag fed back from computational_unit. An internal LIFO return stack holds return addresses, with sticky overflow and underflow error flags.

---
 rtl/program_sequencer.sv | 78 +++++++
 tb/tb_program_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program counter with jump, call/return and a LIFO return stack
module program_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           jmp,
  input  logic                           jmp_nz,
  input  logic                           jsr,
  input  logic                           rts,
  input  logic [ADDR_WIDTH-1:0]          jmp_addr,
  input  logic                           r_eq_0,
  output logic [ADDR_WIDTH-1:0]          pm_addr,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stack_overflow,
  output logic                           stack_underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      top_idx;
  logic                  stack_empty;
  logic                  stack_full;

  assign pc_inc      = pc + ADDR_WIDTH'(1);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  // Low bits of sp address the next free slot; only used when the stack is not full.
  assign push_idx    = sp[IDX_W-1:0];
  assign top_idx     = sp[IDX_W-1:0] - IDX_W'(1);

  assign pm_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc              <= '0;
      sp              <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
    end else if (!stall) begin
      if (rts) begin
        if (!stack_empty) begin
          pc <= stack_mem[top_idx];
          sp <= sp - SP_W'(1);
        end else begin
          pc              <= pc_inc;
          stack_underflow <= 1'b1;
        end
      end else if (jsr) begin
        // The jump is taken even when the push is refused.
        if (!stack_full) begin
          stack_mem[push_idx] <= pc_inc;
          sp                  <= sp + SP_W'(1);
        end else begin
          stack_overflow <= 1'b1;
        end
        pc <= jmp_addr;
      end else if (jmp) begin
        pc <= jmp_addr;
      end else if (jmp_nz && !r_eq_0) begin
        pc <= jmp_addr;
      end else begin
        pc <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - bench for program_sequencer with a queue-based reference model
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall, jmp, jmp_nz, jsr, rts, r_eq_0;
  logic [7:0] jmp_addr;
  logic [7:0] pm_addr, pc;
  logic [2:0] sp;
  logic       stack_overflow, stack_underflow;

  int n_cmp = 0;
  int n_err = 0;

  program_sequencer #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .jmp             (jmp),
    .jmp_nz          (jmp_nz),
    .jsr             (jsr),
    .rts             (rts),
    .jmp_addr        (jmp_addr),
    .r_eq_0          (r_eq_0),
    .pm_addr         (pm_addr),
    .pc              (pc),
    .sp              (sp),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: the return stack is a plain queue, occupancy is its size.
  logic [7:0] m_pc;
  logic [7:0] m_stk [$];
  logic       m_ovf, m_unf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stall) begin
      if (rts) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc  = m_pc + 8'd1;
          m_unf = 1'b1;
        end
      end else if (jsr) begin
        if (m_stk.size() < 4) m_stk.push_back(m_pc + 8'd1);
        else m_ovf = 1'b1;
        m_pc = jmp_addr;
      end else if (jmp) begin
        m_pc = jmp_addr;
      end else if (jmp_nz && r_eq_0 == 1'b0) begin
        m_pc = jmp_addr;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_pc", int'(pc), int'(m_pc));
    check("model_pm_addr", int'(pm_addr), int'(m_pc));
    check("model_sp", int'(sp), m_stk.size());
    check("model_ovf", int'(stack_overflow), int'(m_ovf));
    check("model_unf", int'(stack_underflow), int'(m_unf));
  end

  // One cycle of stimulus: c = {rts, jsr, jmp, jmp_nz}.
  task automatic cyc(input logic [3:0] c, input logic [7:0] a, input logic z, input logic s);
    {rts, jsr, jmp, jmp_nz} = c;
    jmp_addr = a;
    r_eq_0   = z;
    stall    = s;
    @(negedge clk);
    {rts, jsr, jmp, jmp_nz} = 4'b0000;
    stall = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000, 8'h00, 1'b1, 1'b0);
  endtask

  localparam logic [3:0] C_RTS = 4'b1000, C_JSR = 4'b0100, C_JMP = 4'b0010, C_JNZ = 4'b0001;

  initial begin
    reset = 1'b1; stall = 1'b0; jmp = 1'b0; jmp_nz = 1'b0; jsr = 1'b0; rts = 1'b0;
    r_eq_0 = 1'b1; jmp_addr = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_pc", int'(pc), 0);
    check("reset_pm_addr", int'(pm_addr), 0);
    check("reset_sp", int'(sp), 0);
    reset = 1'b0;

    idle(5);
    check("idle5_pc", int'(pc), 5);
    check("idle5_flags", int'({stack_overflow, stack_underflow}), 0);

    cyc(C_JSR, 8'h20, 1'b1, 1'b0);
    idle(2);
    check("call1_pc", int'(pc), 8'h22);
    cyc(C_JSR, 8'h30, 1'b1, 1'b0);
    check("call2_sp", int'(sp), 2);
    idle(1);
    cyc(C_RTS, 8'h00, 1'b1, 1'b0);
    check("ret1_pc", int'(pc), 8'h23);
    check("ret1_sp", int'(sp), 1);
    cyc(C_RTS, 8'h00, 1'b1, 1'b0);
    check("ret2_pc", int'(pc), 8'h06);
    check("ret2_sp", int'(sp), 0);

    cyc(C_JMP, 8'h10, 1'b1, 1'b0);
    cyc(C_JNZ, 8'h40, 1'b1, 1'b0);
    check("jnz_not_taken", int'(pc), 8'h11);
    cyc(C_JNZ, 8'h40, 1'b0, 1'b0);
    check("jnz_taken", int'(pc), 8'h40);

    for (int i = 0; i < 5; i++) cyc(C_JSR, 8'h80, 1'b1, 1'b0);
    check("ovf_sp", int'(sp), 4);
    check("ovf_flag", int'(stack_overflow), 1);
    check("ovf_pc", int'(pc), 8'h80);
    cyc(C_RTS, 8'h00, 1'b1, 1'b0);
    check("pop1_pc", int'(pc), 8'h81);
    for (int i = 0; i < 3; i++) cyc(C_RTS, 8'h00, 1'b1, 1'b0);
    check("pop4_pc", int'(pc), 8'h41);
    check("pop4_unf", int'(stack_underflow), 0);
    cyc(C_RTS, 8'h00, 1'b1, 1'b0);
    check("unf_pc", int'(pc), 8'h42);
    check("unf_flag", int'(stack_underflow), 1);

    cyc(C_JMP, 8'hFF, 1'b1, 1'b0);
    idle(1);
    check("wrap_pc", int'(pc), 8'h00);
    cyc(C_JMP, 8'hFF, 1'b1, 1'b0);
    cyc(C_JSR, 8'h10, 1'b1, 1'b0);
    check("wrap_call_sp", int'(sp), 1);
    cyc(C_RTS | C_JMP, 8'h55, 1'b1, 1'b0);
    check("prio_rts_pc", int'(pc), 8'h00);
    check("prio_rts_sp", int'(sp), 0);

    idle(1);
    for (int i = 0; i < 3; i++) cyc(C_JMP, 8'h77, 1'b0, 1'b1);
    check("stall_pc", int'(pc), 8'h01);
    cyc(C_JSR, 8'h60, 1'b1, 1'b0);
    cyc(C_JSR, 8'h70, 1'b1, 1'b0);
    check("pre_reset_sp", int'(sp), 2);

    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_pc", int'(pc), 0);
    check("async_sp", int'(sp), 0);
    check("async_flags", int'({stack_overflow, stack_underflow}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    check("post_reset_pc", int'(pc), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
